// File: rtl/tsb_bus_arbiter_if.sv
// Bus-side handshake for the tri-state bus arbiter: level requests in, one-hot
// writer enables, owner index and status pulses out.
interface tsb_bus_arbiter_if #(
    parameter int N       = 4,
    parameter int OWNER_W = 2
);
    logic [N-1:0]       io_req;
    logic [N-1:0]       io_grant;
    logic [OWNER_W-1:0] io_owner;
    logic               io_busy;
    logic               io_preempt;

    modport master (output io_req, input io_grant, io_owner, io_busy, io_preempt);
    modport slave  (input io_req, output io_grant, io_owner, io_busy, io_preempt);
endinterface

// File: rtl/tsb_bus_arbiter.sv
// Round-robin owner sequencer for a shared tri-state bus: one writer enable at a
// time, dead cycles between owners, and a hold limit when others are waiting.
module tsb_bus_arbiter #(
    parameter int N        = 4,
    parameter int OWNER_W  = 2,
    parameter int MAX_HOLD = 8,
    parameter int TURN     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    tsb_bus_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TURN_W = (TURN > 1) ? $clog2(TURN) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURN - 1);
    localparam logic [TURN_W-1:0]  TURN_ONE  = TURN_W'(1);
    localparam logic [TURN_W-1:0]  TURN_ZERO = {TURN_W{1'b0}};
    localparam logic [N-1:0]       ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]       NO_GRANT  = {N{1'b0}};
    localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    state_e             state_r, state_next_s;
    logic [HOLD_W-1:0]  hold_cnt_r, hold_next_s;
    logic [TURN_W-1:0]  turn_cnt_r, turn_next_s;
    logic [N-1:0]       grant_r, grant_next_s;
    logic [OWNER_W-1:0] owner_r, owner_next_s;
    logic               busy_r, busy_next_s;
    logic               preempt_r, preempt_next_s;

    logic [OWNER_W-1:0] win_s;
    logic               any_req_s, owner_req_s, other_req_s, hold_sat_s, enter_grant_s;

    // First requester strictly after 'last', wrapping; 'last' itself is tried at the end.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [N-1:0] req,
                                                   input logic [OWNER_W-1:0] last);
        logic [OWNER_W-1:0] win;
        logic [OWNER_W-1:0] idx;
        logic               found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = OWNER_W'((int'(last) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return win;
    endfunction

    assign win_s       = rr_pick(bus.io_req, owner_r);
    assign any_req_s   = |bus.io_req;
    assign owner_req_s = bus.io_req[owner_r];
    assign other_req_s = |(bus.io_req & ~(ONE_HOT0 << owner_r));
    assign hold_sat_s  = (hold_cnt_r == HOLD_LAST);

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= HOLD_ZERO;
            turn_cnt_r <= TURN_ZERO;
        end else begin
            state_r    <= state_next_s;
            hold_cnt_r <= hold_next_s;
            turn_cnt_r <= turn_next_s;
        end
    end

    // Next-state and counter logic; voluntary release takes priority over the hold limit.
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_cnt_r;
        turn_next_s  = turn_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_GRANT;
                    hold_next_s  = HOLD_ZERO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s || (hold_sat_s && other_req_s)) begin
                    state_next_s = ST_TURN;
                    turn_next_s  = TURN_ZERO;
                end else if (!hold_sat_s) begin
                    hold_next_s  = hold_cnt_r + HOLD_ONE;
                end else begin
                    hold_next_s  = hold_cnt_r;
                end
            end
            ST_TURN: begin
                if (turn_cnt_r == TURN_LAST) begin
                    turn_next_s = TURN_ZERO;
                    if (any_req_s) begin
                        state_next_s = ST_GRANT;
                        hold_next_s  = HOLD_ZERO;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    turn_next_s = turn_cnt_r + TURN_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                hold_next_s  = HOLD_ZERO;
                turn_next_s  = TURN_ZERO;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the state transition.
    always_comb begin
        enter_grant_s = (state_r != ST_GRANT) && (state_next_s == ST_GRANT);
        grant_next_s  = NO_GRANT;
        owner_next_s  = owner_r;
        if (enter_grant_s) begin
            grant_next_s = ONE_HOT0 << win_s;
            owner_next_s = win_s;
        end else if (state_next_s == ST_GRANT) begin
            grant_next_s = grant_r;
        end else begin
            grant_next_s = NO_GRANT;
        end
        busy_next_s = (state_next_s == ST_GRANT);
        // Leaving GRANT while the owner still requests can only be the hold limit.
        if ((state_r == ST_GRANT) && (state_next_s == ST_TURN) && owner_req_s) begin
            preempt_next_s = 1'b1;
        end else begin
            preempt_next_s = 1'b0;
        end
    end

    // Output registers; reset drops every writer enable without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_r   <= NO_GRANT;
            owner_r   <= OWNER_RST;
            busy_r    <= 1'b0;
            preempt_r <= 1'b0;
        end else begin
            grant_r   <= grant_next_s;
            owner_r   <= owner_next_s;
            busy_r    <= busy_next_s;
            preempt_r <= preempt_next_s;
        end
    end

    assign bus.io_grant   = grant_r;
    assign bus.io_owner   = owner_r;
    assign bus.io_busy    = busy_r;
    assign bus.io_preempt = preempt_r;

endmodule

// File: tb/tb_tsb_bus_arbiter.sv
// Directed bench for tsb_bus_arbiter (N=4, MAX_HOLD=8, TURN=1) plus a random
// mutual-exclusion / fairness sweep.
module tb_tsb_bus_arbiter;

    localparam int N            = 4;
    localparam int OWNER_W      = 2;
    localparam int MAX_HOLD     = 8;
    localparam int TURN         = 1;
    localparam int STARVE_BOUND = (N - 1) * (MAX_HOLD + TURN) + TURN;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    tsb_bus_arbiter_if #(.N(N), .OWNER_W(OWNER_W)) bus_if ();

    tsb_bus_arbiter #(.N(N), .OWNER_W(OWNER_W), .MAX_HOLD(MAX_HOLD), .TURN(TURN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        bus_if.io_req = 4'b1111;
        #2;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", bus_if.io_grant); end
        n_cmp++; if (bus_if.io_owner !== 2'd3) begin n_err++; $display("FAIL reset_owner: got %0d want 3", bus_if.io_owner); end
        n_cmp++; if (bus_if.io_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_if.io_busy); end
        n_cmp++; if (bus_if.io_preempt !== 1'b0) begin n_err++; $display("FAIL reset_preempt: got %b want 0", bus_if.io_preempt); end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0001) begin n_err++; $display("FAIL first_grant: got %b want 0001", bus_if.io_grant); end
        n_cmp++; if (bus_if.io_owner !== 2'd0) begin n_err++; $display("FAIL first_owner: got %0d want 0", bus_if.io_owner); end
        n_cmp++; if (bus_if.io_busy !== 1'b1) begin n_err++; $display("FAIL first_busy: got %b want 1", bus_if.io_busy); end
        bus_if.io_req = 4'b0000;
        idle_cycles(3);
    endtask

    task automatic test_single();
        bus_if.io_req = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++; if (bus_if.io_grant !== 4'b0100) begin n_err++; $display("FAIL single_grant c%0d: got %b want 0100", k, bus_if.io_grant); end
            n_cmp++; if (bus_if.io_owner !== 2'd2 || bus_if.io_busy !== 1'b1 || bus_if.io_preempt !== 1'b0) begin
                n_err++; $display("FAIL single_status c%0d: got owner=%0d busy=%b pre=%b want 2/1/0", k, bus_if.io_owner, bus_if.io_busy, bus_if.io_preempt);
            end
        end
        bus_if.io_req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0000 || bus_if.io_busy !== 1'b0) begin n_err++; $display("FAIL single_dead: got grant=%b busy=%b want 0000/0", bus_if.io_grant, bus_if.io_busy); end
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0000 || bus_if.io_busy !== 1'b0 || bus_if.io_owner !== 2'd2) begin
            n_err++; $display("FAIL single_idle: got grant=%b busy=%b owner=%0d want 0000/0/2", bus_if.io_grant, bus_if.io_busy, bus_if.io_owner);
        end
        idle_cycles(2);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        reset_n = 1'b0;
        bus_if.io_req = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.io_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << (t % N);
            for (int c = 0; c < MAX_HOLD; c++) begin
                @(negedge clk);
                n_cmp++; if (bus_if.io_grant !== exp_g || bus_if.io_preempt !== 1'b0) begin
                    n_err++; $display("FAIL rr_tenure t%0d c%0d: got grant=%b pre=%b want %b/0", t, c, bus_if.io_grant, bus_if.io_preempt, exp_g);
                end
            end
            @(negedge clk);
            n_cmp++; if (bus_if.io_grant !== 4'b0000 || bus_if.io_preempt !== 1'b1 || bus_if.io_busy !== 1'b0) begin
                n_err++; $display("FAIL rr_dead t%0d: got grant=%b pre=%b busy=%b want 0000/1/0", t, bus_if.io_grant, bus_if.io_preempt, bus_if.io_busy);
            end
        end
        bus_if.io_req = 4'b0000;
        idle_cycles(2);
    endtask

    task automatic test_hold_sat();
        bus_if.io_req = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_cmp++; if (bus_if.io_grant !== 4'b0100 || bus_if.io_preempt !== 1'b0) begin
                n_err++; $display("FAIL hold_sat c%0d: got grant=%b pre=%b want 0100/0", k, bus_if.io_grant, bus_if.io_preempt);
            end
        end
        bus_if.io_req = 4'b0101;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0000 || bus_if.io_preempt !== 1'b1) begin n_err++; $display("FAIL hold_preempt: got grant=%b pre=%b want 0000/1", bus_if.io_grant, bus_if.io_preempt); end
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0001 || bus_if.io_owner !== 2'd0) begin n_err++; $display("FAIL hold_next: got grant=%b owner=%0d want 0001/0", bus_if.io_grant, bus_if.io_owner); end
        bus_if.io_req = 4'b0000;
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        bus_if.io_req = 4'b0011;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0010) begin n_err++; $display("FAIL b2b_first: got %b want 0010", bus_if.io_grant); end
        bus_if.io_req = 4'b0001;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0000 || bus_if.io_preempt !== 1'b0) begin n_err++; $display("FAIL b2b_dead: got grant=%b pre=%b want 0000/0", bus_if.io_grant, bus_if.io_preempt); end
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0001 || bus_if.io_owner !== 2'd0) begin n_err++; $display("FAIL b2b_second: got grant=%b owner=%0d want 0001/0", bus_if.io_grant, bus_if.io_owner); end
        bus_if.io_req = 4'b1000;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0000) begin n_err++; $display("FAIL b2b_dead2: got %b want 0000", bus_if.io_grant); end
        // requester 3 withdraws during the dead cycle and must not be granted
        bus_if.io_req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0100 || bus_if.io_owner !== 2'd2) begin n_err++; $display("FAIL turn_drop: got grant=%b owner=%0d want 0100/2", bus_if.io_grant, bus_if.io_owner); end
        bus_if.io_req = 4'b1100;
        for (int k = 1; k < MAX_HOLD; k++) begin
            @(negedge clk);
            n_cmp++; if (bus_if.io_grant !== 4'b0100 || bus_if.io_preempt !== 1'b0) begin
                n_err++; $display("FAIL simul_hold c%0d: got grant=%b pre=%b want 0100/0", k, bus_if.io_grant, bus_if.io_preempt);
            end
        end
        bus_if.io_req = 4'b1000;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0000 || bus_if.io_preempt !== 1'b0) begin n_err++; $display("FAIL simul_release: got grant=%b pre=%b want 0000/0", bus_if.io_grant, bus_if.io_preempt); end
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b1000 || bus_if.io_owner !== 2'd3) begin n_err++; $display("FAIL simul_next: got grant=%b owner=%0d want 1000/3", bus_if.io_grant, bus_if.io_owner); end
        bus_if.io_req = 4'b0000;
        idle_cycles(3);
    endtask

    task automatic test_async_reset();
        bus_if.io_req = 4'b0010;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0010) begin n_err++; $display("FAIL ar_pre: got %b want 0010", bus_if.io_grant); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus_if.io_grant !== 4'b0000 || bus_if.io_busy !== 1'b0) begin n_err++; $display("FAIL ar_immediate: got grant=%b busy=%b want 0000/0", bus_if.io_grant, bus_if.io_busy); end
        n_cmp++; if (bus_if.io_owner !== 2'd3) begin n_err++; $display("FAIL ar_owner: got %0d want 3", bus_if.io_owner); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_if.io_grant !== 4'b0010 || bus_if.io_owner !== 2'd1 || bus_if.io_busy !== 1'b1) begin
            n_err++; $display("FAIL ar_resume: got grant=%b owner=%0d busy=%b want 0010/1/1", bus_if.io_grant, bus_if.io_owner, bus_if.io_busy);
        end
        bus_if.io_req = 4'b0000;
        idle_cycles(3);
    endtask

    task automatic test_random();
        logic [N-1:0] req_v;
        logic [N-1:0] prev_g;
        logic [N-1:0] g;
        int           zero_run;
        bit           seen;
        int           wait_c [N];
        int           max_wait;
        req_v    = 4'b0000;
        prev_g   = 4'b0000;
        zero_run = 0;
        seen     = 1'b0;
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            g = bus_if.io_grant;
            n_cmp++; if (!$onehot0(g) || (bus_if.io_busy !== (|g))) begin
                n_err++; $display("FAIL rand_onehot c%0d: got grant=%b busy=%b want one-hot-or-zero, busy=OR", cyc, g, bus_if.io_busy);
            end
            if (g != 4'b0000) begin
                if (prev_g == 4'b0000 && seen) begin
                    n_cmp++; if (zero_run < TURN) begin n_err++; $display("FAIL rand_gap c%0d: got %0d dead cycles want >=%0d", cyc, zero_run, TURN); end
                end
                if (prev_g != 4'b0000) begin
                    n_cmp++; if (g != prev_g) begin n_err++; $display("FAIL rand_switch c%0d: got %b after %b want dead cycle between", cyc, g, prev_g); end
                end
                zero_run = 0;
                seen     = 1'b1;
            end else begin
                zero_run++;
            end
            for (int i = 0; i < N; i++) begin
                if (bus_if.io_req[i] && !g[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
            prev_g = g;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7, 0) == 0) req_v[i] = ~req_v[i];
            end
            bus_if.io_req = req_v;
        end
        n_cmp++; if (max_wait > STARVE_BOUND) begin n_err++; $display("FAIL rand_starve: got max wait %0d want <=%0d", max_wait, STARVE_BOUND); end
        bus_if.io_req = 4'b0000;
        idle_cycles(3);
    endtask

    initial begin
        reset_n       = 1'b1;
        bus_if.io_req = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_sat();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
